// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the default operand width.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder_always.sv
// 1-bit full adder cell: s = a0 ^ a1 ^ c0, c1 = majority(a0, a1, c0).
module full_adder_always (
    input  logic a0,
    input  logic a1,
    input  logic c0,
    output logic s,
    output logic c1
);

    always_comb begin
        s  = a0 ^ a1 ^ c0;
        c1 = (a0 & a1) | (a0 & c0) | (a1 & c0);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: feeds one operand bit pair per clock (LSB first) through a single full adder
// cell and presents a registered WIDTH-bit sum, carry-out and a one-cycle done pulse.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] psum_q;
    logic [WIDTH-1:0] psum_d;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             fa_s;
    logic             fa_c1;

    full_adder_always u_fa (
        .a0 (op_a_q[0]),
        .a1 (op_b_q[0]),
        .c0 (carry_q),
        .s  (fa_s),
        .c1 (fa_c1)
    );

    // Each new sum bit enters at the MSB, so after WIDTH shifts bit 0 lands in position 0.
    assign psum_d = {fa_s, psum_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            psum_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_a_q  <= a;
                        op_b_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    op_a_q  <= {1'b0, op_a_q[WIDTH-1:1]};
                    op_b_q  <= {1'b0, op_b_q[WIDTH-1:1]};
                    psum_q  <= psum_d;
                    carry_q <= fa_c1;
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= psum_d;
                        cout_q  <= fa_c1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8: latency, carry, ignored restart, reset abort, back-to-back.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks;
    int errors;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until done is seen or the budget runs out; cycles reports ticks taken.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        tick();
        tick();
        start = 1'b0;
        checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b, required all zero", busy, done, sum, cout);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
        end
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        int busy_cycles;
        busy_cycles = 0;
        issue(8'h5A, 8'h33, 1'b0);
        for (int i = 0; i < W; i++) begin
            if (busy === 1'b1 && done === 1'b0) busy_cycles++;
            tick();
        end
        checks++;
        if (busy_cycles != 8) begin
            errors++;
            $display("FAIL basic_busy: busy cycles=%0d, required 8", busy_cycles);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_timing: done=%b busy=%b 8 cycles after start, required 1 0", done, busy);
        end
        checks++;
        if (sum !== 8'h8D || cout !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: sum=%h cout=%b, required 8d 0", sum, cout);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: done=%b one cycle later, required 0", done);
        end
        $display("test_basic: 5a+33+0 -> sum=%h cout=%b", sum, cout);
    endtask

    task automatic test_carry();
        int cyc;
        issue(8'hFF, 8'h01, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc != 8 || sum !== 8'h00 || cout !== 1'b1) begin
            errors++;
            $display("FAIL carry_ff_01: cycles=%0d sum=%h cout=%b, required 8 00 1", cyc, sum, cout);
        end
        $display("test_carry: ff+01+0 -> sum=%h cout=%b", sum, cout);
        tick();
        issue(8'hFF, 8'hFF, 1'b1);
        wait_done(cyc);
        checks++;
        if (cyc != 8 || sum !== 8'hFF || cout !== 1'b1) begin
            errors++;
            $display("FAIL carry_ff_ff_1: cycles=%0d sum=%h cout=%b, required 8 ff 1", cyc, sum, cout);
        end
        $display("test_carry: ff+ff+1 -> sum=%h cout=%b", sum, cout);
        tick();
    endtask

    task automatic test_start_ignored();
        int cyc;
        issue(8'h10, 8'h20, 1'b0);
        tick();
        tick();
        start = 1'b1;
        a = 8'hAA; b = 8'hAA; cin = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (sum !== 8'hFF || cout !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_prev: sum=%h cout=%b busy=%b mid-run, required ff 1 1", sum, cout, busy);
        end
        wait_done(cyc);
        checks++;
        if (cyc != 5 || sum !== 8'h30 || cout !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: cycles=%0d sum=%h cout=%b, required 5 30 0", cyc, sum, cout);
        end
        $display("test_start_ignored: 10+20 -> sum=%h cout=%b", sum, cout);
        tick();
    endtask

    task automatic test_reset_midrun();
        int done_seen;
        done_seen = 0;
        issue(8'h7F, 8'h01, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun: busy=%b done=%b sum=%h cout=%b, required 0 0 00 0", busy, done, sum, cout);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL reset_no_done: activity cycles=%0d after abort, required 0", done_seen);
        end
        $display("test_reset_midrun: aborted, sum=%h", sum);
    endtask

    task automatic test_back_to_back();
        int cyc;
        issue(8'h0F, 8'h01, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc != 8 || sum !== 8'h10 || cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: cycles=%0d sum=%h cout=%b, required 8 10 0", cyc, sum, cout);
        end
        issue(8'h01, 8'h02, 1'b1);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h10) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b done=%b sum=%h, required 1 0 10", busy, done, sum);
        end
        wait_done(cyc);
        checks++;
        if (cyc + 1 != 9 || sum !== 8'h04 || cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: done spacing=%0d sum=%h cout=%b, required 9 04 0", cyc + 1, sum, cout);
        end
        $display("test_back_to_back: 01+02+1 -> sum=%h cout=%b", sum, cout);
        tick();
    endtask

    task automatic test_random();
        int cyc;
        int bad;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   exp;
        bad = 0;
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            exp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            issue(ra, rb, rc);
            wait_done(cyc);
            checks++;
            if (cyc != 8 || {cout, sum} !== exp) begin
                errors++;
                bad++;
                $display("FAIL random_%0d: %h+%h+%b cycles=%0d got=%h, required 8 %h", n, ra, rb, rc, cyc, {cout, sum}, exp);
            end
            tick();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                bad++;
                $display("FAIL random_width_%0d: done=%b second cycle, required 0", n, done);
            end
        end
        $display("test_random: 1000 ops, %0d bad", bad);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_start_ignored();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder built around the team's 1-bit full adder cell (full_adder_always).
- Accepts two WIDTH-bit operands and a carry-in on a start strobe.
- Feeds the full adder one bit pair per clock, LSB first, and captures each sum bit and the carry-out.
- Presents a registered WIDTH-bit sum and carry-out with a done pulse. Sits directly upstream of, and wraps, the full adder in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  request to begin an addition; operands sampled on the same edge
- a  input  WIDTH  addend A
- b  input  WIDTH  addend B
- cin  input  1  carry-in to bit 0
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: sum/cout hold a new result
- sum  output  WIDTH  registered result, stable until the next completion
- cout  output  1  registered carry-out of bit WIDTH-1

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and bit counter are cleared.
  - Reset overrides start and any in-flight operation; a partial result is discarded and sum/cout go to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge T0 loads a and b into operand shift registers and cin into the carry flop.
  - Bit counter is cleared to 0; go to RUN. start=0 stays in IDLE.
- RUN (busy=1):
  - The full adder sees a0=opA[0], a1=opB[0], c0=carry flop.
  - At each edge, opA and opB shift right by 1.
  - The full adder s is shifted into the MSB of the partial-sum register, which shifts right.
  - The carry flop takes c1; the counter increments.
  - The edge where the counter equals WIDTH-1 processes the final bit. On that edge: sum <= completed partial-sum value, cout <= c1, go to DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle.
  - Next edge: start=1 behaves exactly as start in IDLE (back-to-back op, goes to RUN); otherwise go to IDLE.
- Latency:
  - start sampled at T0; bits processed at edges T1..TWIDTH.
  - done is high in the cycle after TWIDTH, so the result is visible WIDTH cycles after the start edge.
  - Throughput is one addition per WIDTH+1 cycles.
- start while in RUN is ignored: operands are not resampled and in-flight data is unaffected.
- sum/cout change only at the final-bit edge or at reset. They hold the previous result throughout a new RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Counter width is $clog2(WIDTH); the counter never exceeds WIDTH-1.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default WIDTH constant.
- One sub-module: the existing 1-bit full adder full_adder_always, instantiated once and driven from the operand LSBs and carry flop.
- Everything else (shift registers, counter, FSM, result registers) stays in serial_adder_ctrl.

Test Plan (WIDTH=8):
- Reset, then start with a=0x5A, b=0x33, cin=0 -> busy high 8 cycles; done pulses 8 cycles after the start edge; sum=0x8D, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start a=0x10, b=0x20; pulse start again mid-RUN with a=0xAA, b=0xAA -> second start ignored; result sum=0x30, cout=0; previous sum held until completion.
- Start a=0x7F, b=0x01; drive rst_n=0 at the 4th RUN cycle -> next edge: IDLE, busy=0, done=0, sum=0x00, cout=0; no done pulse follows.
- Back-to-back: hold start high in the DONE cycle with a=0x01, b=0x02, cin=1 -> first result is reported, then the new op runs; second done shows sum=0x04, cout=0 exactly 9 cycles after the first done.
- Random a/b/cin, 1000 ops, compared against a + b + cin -> zero mismatches; done always exactly one cycle wide.
